// File: rtl/seq_approx_rc_adder_if.sv
// Operand/result handshake bundle for seq_approx_rc_adder.
// The master drives operands and result acceptance. The slave is the adder itself.
interface seq_approx_rc_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] IN1;
  logic [WIDTH-1:0] IN2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   Out;
  logic [WIDTH:0]   Exact;
  logic             err_flag;

  modport master (
    output in_valid, IN1, IN2, out_ready,
    input  in_ready, out_valid, Out, Exact, err_flag
  );

  modport slave (
    input  in_valid, IN1, IN2, out_ready,
    output in_ready, out_valid, Out, Exact, err_flag
  );
endinterface

// File: rtl/seq_approx_rc_adder.sv
// Multi-cycle approximate ripple-carry adder. Each cycle it computes CHUNK bits through a
// truth-table-defined cell and through an exact adder, and flags the result when the two differ.
module seq_approx_rc_adder #(
  parameter int         WIDTH       = 16,
  parameter int         CHUNK       = 4,
  parameter int         APPROX_BITS = 15,
  parameter logic [7:0] SUM_TT      = 8'd42,
  parameter logic [7:0] COUT_TT     = 8'd255
) (
  input logic clk,
  input logic rst,
  seq_approx_rc_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_approx_rc_adder: WIDTH must be a positive multiple of CHUNK");
  end
  if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
    $error("seq_approx_rc_adder: APPROX_BITS must lie in 0..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Table bit 7 holds the output for XYZ=000, bit 0 the output for XYZ=111.
  function automatic logic tt_lookup(input logic [7:0] tt, input logic x, input logic y,
                                     input logic z);
    tt_lookup = tt[3'd7 - {x, y, z}];
  endfunction

  // Ripples one chunk through approximate or exact cells by absolute bit position.
  function automatic logic [CHUNK:0] approx_chunk(input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y,
                                                  input logic cin, input int base);
    logic             c;
    logic [CHUNK-1:0] s;
    c = cin;
    s = {CHUNK{1'b0}};
    for (int j = 0; j < CHUNK; j++) begin
      if (base + j < APPROX_BITS) begin
        s[j] = tt_lookup(SUM_TT, x[j], y[j], c);
        c    = tt_lookup(COUT_TT, x[j], y[j], c);
      end else begin
        s[j] = x[j] ^ y[j] ^ c;
        c    = (x[j] & y[j]) | (x[j] & c) | (y[j] & c);
      end
    end
    approx_chunk = {c, s};
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_app_r;
  logic             carry_ex_r;
  logic [WIDTH:0]   out_r;
  logic [WIDTH:0]   exact_r;
  logic             err_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [CHUNK:0]   app_chunk_s;
  logic [CHUNK:0]   ex_chunk_s;
  logic [WIDTH-1:0] out_shift_s;
  logic [WIDTH-1:0] exact_shift_s;

  // Operands are shifted down so the current chunk always sits in the low bits;
  // results shift in from the top so bit 0 lands in place after N cycles.
  always_comb begin
    app_chunk_s   = approx_chunk(a_r[CHUNK-1:0], b_r[CHUNK-1:0], carry_app_r,
                                 int'(cnt_r) * CHUNK);
    ex_chunk_s    = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_ex_r};
    out_shift_s   = WIDTH'({app_chunk_s[CHUNK-1:0], out_r[WIDTH-1:0]} >> CHUNK);
    exact_shift_s = WIDTH'({ex_chunk_s[CHUNK-1:0], exact_r[WIDTH-1:0]} >> CHUNK);
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      carry_app_r <= 1'b0;
      carry_ex_r  <= 1'b0;
      out_r       <= {(WIDTH+1){1'b0}};
      exact_r     <= {(WIDTH+1){1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r         <= bus.IN1;
            b_r         <= bus.IN2;
            carry_app_r <= 1'b0;
            carry_ex_r  <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            state_r     <= RUN;
          end else begin
            in_ready_r  <= 1'b1;
          end
        end
        RUN: begin
          a_r         <= a_r >> CHUNK;
          b_r         <= b_r >> CHUNK;
          carry_app_r <= app_chunk_s[CHUNK];
          carry_ex_r  <= ex_chunk_s[CHUNK];
          cnt_r       <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(N - 1)) begin
            out_r       <= {app_chunk_s[CHUNK], out_shift_s};
            exact_r     <= {ex_chunk_s[CHUNK], exact_shift_s};
            err_r       <= {app_chunk_s[CHUNK], out_shift_s} != {ex_chunk_s[CHUNK], exact_shift_s};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            out_r[WIDTH-1:0]   <= out_shift_s;
            exact_r[WIDTH-1:0] <= exact_shift_s;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Out       = out_r;
  assign bus.Exact     = exact_r;
  assign bus.err_flag  = err_r;
endmodule
